elpis_output_fifo: RTL
======================

// Module: elpis_output_fifo
// PURPOSE
//  Downstream capture stage for Elpis console output. Latches each 32-bit word the core
//  presents (data + output-enable) into a small FIFO so the PicoRV firmware, polling over
//  the logic analyser, loses nothing while it is slow. Head word, count and flags feed
//  wbs_dat_o and LA outputs. Host pops and clears via LA bits synchronised into clk.
// PARAMETERS
//  WIDTH        32  data word width
//  DEPTH        8   FIFO entries; power of two, >=2
//  SYNC_STAGES  2   flip-flop stages on each asynchronous host control bit; >=2
// PORTS
//  clk               in   1             core clock (muxed wb_clk_i / LA clock)
//  rst_n             in   1             asynchronous active-low reset
//  elpis_out_data    in   WIDTH         word from Elpis, valid while elpis_out_en high
//  elpis_out_en      in   1             Elpis output enable (level)
//  host_pop_toggle   in   1             LA bit; every edge (0->1 or 1->0) = one pop request
//  host_clear        in   1             LA bit; level, high = flush FIFO and clear flags
//  head_data         out  WIDTH         oldest word; 0 when empty
//  head_valid        out  1             FIFO not empty
//  fifo_count        out  $clog2(DEPTH)+1  words held, 0..DEPTH
//  overflow          out  1             sticky: push arrived while full
//  underflow         out  1             sticky: pop arrived while empty
// BEHAVIOUR
//  - Reset: pointers, count, flags, sync chains, edge-detect regs = 0; head_data = 0,
//    head_valid = 0, fifo_count = 0. Storage array is not reset.
//  - Push event: rising edge of elpis_out_en (registered previous value); a multi-cycle
//    high level is one push. Data sampled in the same cycle as the edge.
//  - Pop event: sync'd host_pop_toggle differs from its registered previous value.
//    Latency host edge -> pop = SYNC_STAGES+1 clk cycles.
//  - host_clear sync'd through SYNC_STAGES; while high: rd/wr ptrs and count -> 0,
//    overflow/underflow -> 0, pushes and pops discarded. Clear wins over everything.
//  - Push accepted at cycle N -> head_valid/fifo_count updated at N+1; head_data is
//    mem[rd_ptr] via registered pointer, valid from N+1.
//  - Full + push, no pop: word dropped, overflow <= 1, FIFO unchanged.
//  - Full + push + pop same cycle: both performed, count stays DEPTH, no overflow.
//  - Empty + pop, no push: ignored, underflow <= 1.
//  - Empty + push + pop same cycle: push performed, pop ignored, underflow <= 1, count 1.
//  - Pointers $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0; count tracked separately.
//  - head_data forced to 0 when count == 0 (no stale data to firmware).
//  - Reset mid-operation: all state returns to reset values immediately (async);
//    post-reset the toggle edge detector holds sync'd level, so no spurious pop.
// STRUCTURE
//  - elpis_pkg: ELPIS_WORD_W = 32; LA bit indices LA_POP_TOGGLE = 101, LA_CLEAR = 102,
//    LA_HEAD_VALID = 103, LA_OVERFLOW = 104, LA_UNDERFLOW = 105, LA_COUNT_LSB = 106.
//  - One sub-module: elpis_sync_bit (SYNC_STAGES-deep synchroniser, async active-low
//    reset to 0), instantiated for host_pop_toggle and host_clear.
//  - FIFO storage, pointers, counter and flag logic inline in this module.
// TESTING
//  1 Reset, then 3 pulses of elpis_out_en with data 0x11,0x22,0x33 -> count 3,
//    head_data 0x11, head_valid 1; toggle pop x3 -> heads 0x22,0x33, then empty, data 0.
//  2 Hold elpis_out_en high 10 cycles with data 0xA5A5A5A5 -> exactly one push, count 1.
//  3 Push 9 words (DEPTH 8) -> count 8, overflow 1, head 1st word, 9th word never seen;
//    simultaneous push+pop when full -> count 8, overflow unchanged by that cycle.
//  4 Pop toggle on empty FIFO -> underflow 1, count 0; same-cycle push+pop on empty ->
//    count 1, head = pushed word.
//  5 Fill 5 words, pulse host_clear 4 cycles -> count 0, flags 0, head_data 0; push
//    during clear ignored; wrap test: 20 push/pop pairs -> data order preserved.
//  6 Assert rst_n low mid-burst (count 4) -> all outputs 0 asynchronously; after release,
//    static host_pop_toggle = 1 produces no pop.

Source files
------------

// File: rtl/elpis_pkg.sv
// Shared constants for the Elpis console-output capture path: word width and the
// logic-analyser bit positions used by the host-side firmware.
package elpis_pkg;

  localparam int ELPIS_WORD_W = 32;

  localparam int LA_POP_TOGGLE = 101;
  localparam int LA_CLEAR      = 102;
  localparam int LA_HEAD_VALID = 103;
  localparam int LA_OVERFLOW   = 104;
  localparam int LA_UNDERFLOW  = 105;
  localparam int LA_COUNT_LSB  = 106;

endpackage

// File: rtl/elpis_sync_bit.sv
// Multi-stage flip-flop synchroniser for one asynchronous host control bit.
// Clears to 0 on reset so the chain never presents an unknown level.
module elpis_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's value from before the edge, giving a true shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/elpis_output_fifo.sv
// Captures each word Elpis presents (rising edge of its output enable) into a small FIFO
// that the slow host firmware drains by toggling an LA bit; host may flush via LA clear.
module elpis_output_fifo
  import elpis_pkg::*;
#(
  parameter int WIDTH       = ELPIS_WORD_W,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         elpis_out_data,
  input  logic                     elpis_out_en,
  input  logic                     host_pop_toggle,
  input  logic                     host_clear,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_DONE  = WARM_W'(SYNC_STAGES + 1);
  localparam logic [AW:0]       FULL_COUNT = (AW + 1)'(DEPTH);

  logic              pop_sync;
  logic              clear_sync;
  logic              en_prev;
  logic              pop_prev;
  logic [WARM_W-1:0] warm_cnt;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic push_ev, pop_ev, full, empty, do_push, do_pop;

  elpis_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pop (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_pop_toggle),
    .sync_out (pop_sync)
  );

  elpis_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_clear),
    .sync_out (clear_sync)
  );

  // The toggle detector stays disarmed until the synchroniser has filled after reset,
  // so a host toggle bit that is already high does not look like a pop request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_prev  <= 1'b0;
      pop_prev <= 1'b0;
      warm_cnt <= '0;
    end else begin
      en_prev  <= elpis_out_en;
      pop_prev <= pop_sync;
      if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  always_comb begin
    push_ev = elpis_out_en && !en_prev;
    pop_ev  = (pop_sync ^ pop_prev) && (warm_cnt == WARM_DONE);
    full    = (count == FULL_COUNT);
    empty   = (count == '0);
    // A pop in the same cycle frees the slot a full FIFO needs for the incoming word.
    do_push = push_ev && (!full || pop_ev) && !clear_sync;
    do_pop  = pop_ev && !empty && !clear_sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_sync) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push_ev && full && !pop_ev) overflow  <= 1'b1;
      if (pop_ev && empty)            underflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; valid words are defined by the pointers and count, and
  // leaving the array out of reset keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= elpis_out_data;
  end

  assign head_valid = !empty;
  assign fifo_count = count;
  assign head_data  = empty ? '0 : mem[rd_ptr];

endmodule
